// File: rtl/uart_pkg.sv
// Shared UART definitions (frame state encoding, default timing) for the rx and tx paths.
package uart_pkg;

   localparam int unsigned DEF_CLKS_PER_BIT = 868;
   localparam int unsigned DEF_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: tick while the count is zero, then reload one bit period.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (tick)
         cnt <= CNT_W'(CLKS_PER_BIT - 1);
      else
         cnt <= cnt - 1'b1;
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8N1 mid-bit sampling, valid/ready output, ferr/ovr/cek pulses.
// Define UART_RX_PARITY_EN for an even-parity bit and the rx_perr output.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxd,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_ferr,
   output logic                 rx_ovr,
`ifdef UART_RX_PARITY_EN
   output logic                 rx_perr,
`endif
   output logic                 rx_busy,
   output logic                 rx_cek
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   uart_state_t          state, state_nxt;
   logic                 rxd_m, rxd_s;
   logic                 tick, t_load;
   logic                 shift_en, frame_end, deliver, ovr_set, ferr_set, perr_set, par_chk;
   logic                 par_bad;
   logic [DATA_BITS-1:0] shreg;
   logic [2:0]           bit_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (CNT_W'(CLKS_PER_BIT / 2 - 1)),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      t_load    = 1'b0;
      shift_en  = 1'b0;
      par_chk   = 1'b0;
      frame_end = 1'b0;
      deliver   = 1'b0;
      ovr_set   = 1'b0;
      ferr_set  = 1'b0;
      perr_set  = 1'b0;
      case (state)
         IDLE:
            if (!rxd_s) begin
               state_nxt = START;
               t_load    = 1'b1;
            end
         START:
            if (tick) state_nxt = rxd_s ? IDLE : DATA;
         DATA:
            if (tick) begin
               shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == 3'(DATA_BITS - 1)) state_nxt = PARITY;
`else
               if (bit_idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
         PARITY:
            if (tick) begin
               par_chk   = 1'b1;
               state_nxt = STOP;
            end
`endif
         STOP:
            // An acceptance in the same cycle frees the holding register first.
            if (tick) begin
               frame_end = 1'b1;
               if (!rxd_s) begin
                  ferr_set  = 1'b1;
                  state_nxt = BREAK;
               end else begin
                  state_nxt = IDLE;
                  if (par_bad)
                     perr_set = 1'b1;
                  else if (rx_valid && !rx_ready)
                     ovr_set = 1'b1;
                  else
                     deliver = 1'b1;
               end
            end
         BREAK:
            if (rxd_s) state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg    <= '0;
         bit_idx  <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_ovr   <= 1'b0;
         rx_cek   <= 1'b0;
      end else begin
         rx_ferr <= ferr_set;
         rx_ovr  <= ovr_set;
         rx_cek  <= frame_end;
         if (shift_en) begin
            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
         end else if (state != DATA) begin
            bit_idx <= '0;
         end
         if (deliver) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_bad <= 1'b0;
         rx_perr <= 1'b0;
      end else begin
         rx_perr <= perr_set;
         if (par_chk) par_bad <= ^{shreg, rxd_s};
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   assign rx_busy = (state != IDLE);

endmodule
